// File: rtl/pc_unit.sv
// Fetch-stage program counter with stall, redirect/exception priority and
// an optional return-address stack built when PC_RAS_EN is defined.
module pc_unit #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h0000_0080),
    parameter int unsigned      INC       = 4,
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_we,
    input  logic             exc_valid,
    input  logic             redir_valid,
    input  logic [WIDTH-1:0] redir_target,
    input  logic             ras_push,
    input  logic [WIDTH-1:0] ras_push_addr,
    input  logic             ras_pop,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus,
    output logic             ras_empty,
    output logic             ras_full
);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_next;
    logic             w_pop;
    logic [WIDTH-1:0] w_ras_top;

    assign pc_out  = r_pc;
    assign pc_plus = r_pc + WIDTH'(INC);

`ifdef PC_RAS_EN
    localparam int unsigned    PTRW     = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PTRW:0]  FULL_CNT = (PTRW + 1)'(RAS_DEPTH);

    logic [WIDTH-1:0] r_stack [RAS_DEPTH];
    logic [PTRW-1:0]  r_top;
    logic [PTRW:0]    r_count;
    logic [PTRW-1:0]  w_top_inc;
    logic             w_push;

    assign w_top_inc = r_top + 1'b1;
    assign w_ras_top = r_stack[r_top];
    assign w_pop     = pc_we & ras_pop & ~exc_valid & ~redir_valid & (r_count != '0);
    assign w_push    = ras_push & ~exc_valid;
    assign ras_empty = (r_count == '0);
    assign ras_full  = (r_count == FULL_CNT);

    // Push+pop replaces the top in place; a plain push when full wraps onto the oldest slot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_top   <= '0;
            r_count <= '0;
        end else if (exc_valid) begin
            r_count <= '0;
        end else if (w_pop && !w_push) begin
            r_top   <= r_top - 1'b1;
            r_count <= r_count - 1'b1;
        end else if (w_push && !w_pop) begin
            r_top <= w_top_inc;
            if (r_count != FULL_CNT) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            if (w_pop) begin
                r_stack[r_top] <= ras_push_addr;
            end else begin
                r_stack[w_top_inc] <= ras_push_addr;
            end
        end
    end
`else
    logic w_unused;

    assign w_pop     = 1'b0;
    assign w_ras_top = '0;
    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
    assign w_unused  = &{1'b0, ras_push, ras_pop, ras_push_addr, (RAS_DEPTH != 0)};
`endif

    always_comb begin
        w_pc_next = r_pc;
        if (exc_valid) begin
            w_pc_next = EXC_VEC;
        end else if (redir_valid) begin
            w_pc_next = redir_target;
        end else if (w_pop) begin
            w_pc_next = w_ras_top;
        end else if (pc_we) begin
            w_pc_next = pc_plus;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc <= RESET_VEC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table, RAS corner
// sequences (PC_RAS_EN builds) and randomized traffic against a queue model.
module tb_pc_unit;

    localparam int unsigned DEPTH = 4;
`ifdef PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pc_we = 1'b0;
    logic        exc_valid = 1'b0;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_target = '0;
    logic        ras_push = 1'b0;
    logic [31:0] ras_push_addr = '0;
    logic        ras_pop = 1'b0;
    logic [31:0] pc_out;
    logic [31:0] pc_plus;
    logic        ras_empty;
    logic        ras_full;

    pc_unit #(
        .WIDTH    (32),
        .RESET_VEC(32'h0),
        .EXC_VEC  (32'h0000_0080),
        .INC      (4),
        .RAS_DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_we        (pc_we),
        .exc_valid    (exc_valid),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .ras_push     (ras_push),
        .ras_push_addr(ras_push_addr),
        .ras_pop      (ras_pop),
        .pc_out       (pc_out),
        .pc_plus      (pc_plus),
        .ras_empty    (ras_empty),
        .ras_full     (ras_full)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: PC value plus a queue holding the return stack (back = top).
    logic [31:0] m_pc = '0;
    logic [31:0] m_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_push(input logic [31:0] a);
        m_q.push_back(a);
        if (m_q.size() > DEPTH) void'(m_q.pop_front());
    endtask

    task automatic model_edge(input logic r, input logic we, input logic ex, input logic rd,
                              input logic [31:0] tgt, input logic pu, input logic [31:0] pa,
                              input logic po);
        if (!r) begin
            m_pc = 32'h0;
            m_q.delete();
        end else if (ex) begin
            m_pc = 32'h80;
            m_q.delete();
        end else if (rd) begin
            m_pc = tgt;
            if (RAS_ON && pu) model_push(pa);
        end else if (RAS_ON && we && po && m_q.size() > 0) begin
            m_pc = m_q.pop_back();
            if (pu) model_push(pa);
        end else begin
            if (we) m_pc = m_pc + 32'd4;
            if (RAS_ON && pu) model_push(pa);
        end
    endtask

    task automatic step(input logic r, input logic we, input logic ex, input logic rd,
                        input logic [31:0] tgt, input logic pu, input logic [31:0] pa,
                        input logic po);
        rst = r; pc_we = we; exc_valid = ex; redir_valid = rd;
        redir_target = tgt; ras_push = pu; ras_push_addr = pa; ras_pop = po;
        @(posedge clk);
        model_edge(r, we, ex, rd, tgt, pu, pa, po);
        #1;
        chk("pc_out", pc_out, m_pc);
        chk("pc_plus", pc_plus, m_pc + 32'd4);
        chk("ras_empty", {31'b0, ras_empty}, {31'b0, (m_q.size() == 0)});
        chk("ras_full", {31'b0, ras_full}, {31'b0, (m_q.size() == DEPTH)});
    endtask

    typedef struct {
        logic        r, we, ex, rd;
        logic [31:0] tgt;
        logic        po;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[16];

    initial begin
        // Directed vectors valid for both builds (RAS stays empty throughout).
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h4};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h8};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'hC};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h10};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h10};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h10};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h200,       1'b0, 32'h200};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h300,       1'b0, 32'h80};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h20,        1'b0, 32'h20};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h24};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h500,       1'b0, 32'h0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0};

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].r, tbl[i].we, tbl[i].ex, tbl[i].rd, tbl[i].tgt, 1'b0, 32'h0, tbl[i].po);
            chk($sformatf("tbl%0d_pc", i), pc_out, tbl[i].exp_pc);
            chk($sformatf("tbl%0d_plus", i), pc_plus, tbl[i].exp_pc + 32'd4);
            chk($sformatf("tbl%0d_empty", i), {31'b0, ras_empty}, 32'd1);
        end

`ifdef PC_RAS_EN
        // Fill past capacity while stalled, then drain including one empty pop.
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'(i * 32'h100), 1'b0);
            if (i >= 4) chk($sformatf("full_after_push%0d", i), {31'b0, ras_full}, 32'd1);
        end
        for (int i = 5; i >= 2; i--) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            chk($sformatf("pop_pc_%0d", i), pc_out, 32'(i * 32'h100));
        end
        chk("drained_empty", {31'b0, ras_empty}, 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("empty_pop_pc", pc_out, 32'h204);

        // Simultaneous push/pop replaces the top; exception clears the stack.
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
        chk("pushpop_pc", pc_out, 32'h40);
        chk("pushpop_not_empty", {31'b0, ras_empty}, 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("pop_after_replace", pc_out, 32'h80);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h11C, 1'b0);
        chk("push_not_empty", {31'b0, ras_empty}, 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h999, 1'b1);
        chk("exc_pc", pc_out, 32'h80);
        chk("exc_clears", {31'b0, ras_empty}, 32'd1);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic        r, we, ex, rd, pu, po;
            logic [31:0] tgt, pa;
            r   = ($urandom_range(0, 49) != 0);
            ex  = ($urandom_range(0, 19) == 0);
            rd  = ($urandom_range(0, 7) == 0);
            we  = ($urandom_range(0, 3) != 0);
            pu  = ($urandom_range(0, 2) == 0);
            po  = ($urandom_range(0, 2) == 0);
            tgt = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFFC;
            pa  = $urandom & 32'h0000_FFFC;
            step(r, we, ex, rd, tgt, pu, pa, po);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
